// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, sequencer states
// and the datapath width. The ALU control unit imports the same op encoding.
package alu_pkg;

   localparam int XLEN = 32;

   // Operation encoding produced by the ALU control unit; 13 and 14 are reserved
   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_SLL    = 4'd2,
      OP_SRL    = 4'd3,
      OP_SRA    = 4'd4,
      OP_XOR    = 4'd5,
      OP_OR     = 4'd6,
      OP_AND    = 4'd7,
      OP_SLT    = 4'd8,
      OP_BEQ    = 4'd9,
      OP_BNE    = 4'd10,
      OP_BLT    = 4'd11,
      OP_BGE    = 4'd12,
      OP_RSV13  = 4'd13,
      OP_RSV14  = 4'd14,
      OP_PASS_B = 4'd15
   } alu_op_t;

   // The sequencer only needs to know whether an iterative shift is in flight
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } exec_state_t;

   // Shifts are the only ops that may take more than one cycle
   function automatic logic isShiftOp(input alu_op_t op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_iter_exec_shift_step.sv
// One step of the iterative shifter: shifts a value by a small amount in either
// direction, with sign fill for arithmetic right shifts.
module alu_shift_step
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] value,
   input  logic [4:0]      amount,
   input  logic            dir,
   input  logic            arith,
   output logic [XLEN-1:0] shifted
);

   // dir=0 shifts left, dir=1 shifts right; arith only matters for right shifts,
   // where it replicates the top bit so repeated steps behave like one SRA
   always_comb begin
      shifted = value;
      if (!dir) begin
         shifted = value << amount;
      end else if (arith) begin
         shifted = $signed(value) >>> amount;
      end else begin
         shifted = value >> amount;
      end
   end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare/branch ops and a
// multi-cycle shifter that moves SHIFT_STEP bits per cycle behind a START/BUSY/DONE handshake.
module alu_iter_exec #(
   parameter int SHIFT_STEP = 1,
   parameter int XLEN       = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic [3:0]      ALUops,
   input  logic            UNSIGNED,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic [XLEN-1:0] RESULT,
   output logic            BRANCH,
   output logic            BUSY,
   output logic            DONE
);

   import alu_pkg::*;

   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   exec_state_t     state;
   exec_state_t     nextState;
   alu_op_t         op;
   logic [XLEN-1:0] shiftReg;
   logic [XLEN-1:0] stepOut;
   logic [XLEN-1:0] aluResult;
   logic            aluBranch;
   logic            isLess;
   logic [4:0]      shamt;
   logic [4:0]      remaining;
   logic [4:0]      stepAmt;
   logic            shiftDir;
   logic            shiftArith;
   logic            accept;
   logic            startShift;
   logic            lastStep;

   assign op         = alu_op_t'(ALUops);
   assign shamt      = B[4:0];
   assign accept     = START && (state == IDLE);
   assign startShift = accept && isShiftOp(op) && (shamt != 5'd0);
   assign stepAmt    = (remaining < STEP) ? remaining : STEP;
   assign lastStep   = (state == SHIFT) && (remaining == stepAmt);
   assign BUSY       = (state == SHIFT);

   // The shift register is walked one step per cycle; direction and fill are
   // latched at acceptance so the operand buses may change while busy
   alu_shift_step shiftStep (
      .value   (shiftReg),
      .amount  (stepAmt),
      .dir     (shiftDir),
      .arith   (shiftArith),
      .shifted (stepOut)
   );

   // UNSIGNED picks the comparison flavour shared by SLT, BLT and BGE
   always_comb begin
      isLess = 1'b0;
      if (UNSIGNED) begin
         isLess = (A < B);
      end else begin
         isLess = ($signed(A) < $signed(B));
      end
   end

   // Single-cycle result path. A shift only lands here when its amount is zero,
   // in which case the answer is simply A; reserved codes produce zero
   always_comb begin
      aluResult = '0;
      aluBranch = 1'b0;
      case (op)
         OP_ADD:    aluResult = A + B;
         OP_SUB:    aluResult = A - B;
         OP_SLL,
         OP_SRL,
         OP_SRA:    aluResult = A;
         OP_XOR:    aluResult = A ^ B;
         OP_OR:     aluResult = A | B;
         OP_AND:    aluResult = A & B;
         OP_SLT:    aluResult = {{(XLEN-1){1'b0}}, isLess};
         OP_BEQ:    aluBranch = (A == B);
         OP_BNE:    aluBranch = (A != B);
         OP_BLT:    aluBranch = isLess;
         OP_BGE:    aluBranch = !isLess;
         OP_PASS_B: aluResult = B;
         default:   aluResult = '0;
      endcase
      if (op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE}) begin
         aluResult = {{(XLEN-1){1'b0}}, aluBranch};
      end
   end

   // State register; reset abandons any shift in flight
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Enter SHIFT only for a real shift amount, and leave on the step that
   // consumes whatever amount is left
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (startShift) nextState = SHIFT;
         SHIFT:   if (lastStep)   nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Datapath and outputs. RESULT/BRANCH only change when an op completes, so
   // the previous answer stays visible for the whole busy period, and DONE is a
   // one-cycle pulse following the completing edge
   always_ff @(posedge CLK) begin
      if (RST) begin
         RESULT     <= '0;
         BRANCH     <= 1'b0;
         DONE       <= 1'b0;
         shiftReg   <= '0;
         remaining  <= '0;
         shiftDir   <= 1'b0;
         shiftArith <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (startShift) begin
            shiftReg   <= A;
            remaining  <= shamt;
            shiftDir   <= (op != OP_SLL);
            shiftArith <= (op == OP_SRA);
         end else if (accept) begin
            RESULT <= aluResult;
            BRANCH <= aluBranch;
            DONE   <= 1'b1;
         end else if (state == SHIFT) begin
            shiftReg  <= stepOut;
            remaining <= remaining - stepAmt;
            if (lastStep) begin
               RESULT <= stepOut;
               BRANCH <= 1'b0;
               DONE   <= 1'b1;
            end
         end
      end
   end

endmodule
